// File: rtl/ex_div_if.sv
// Request/result bundle between the EX stage and the iterative divider.
// The EX stage drives the master side; the divider sits on the slave side.
interface ex_div_if;
    logic        div_start_i;
    logic        div_signed_i;
    logic [31:0] div_opdata_1_i;
    logic [31:0] div_opdata_2_i;
    logic        div_annul_i;
    logic [63:0] div_result_o;
    logic        div_ready_o;
    logic        div_busy_o;

    modport master (
        output div_start_i, div_signed_i, div_opdata_1_i, div_opdata_2_i, div_annul_i,
        input  div_result_o, div_ready_o, div_busy_o
    );

    modport slave (
        input  div_start_i, div_signed_i, div_opdata_1_i, div_opdata_2_i, div_annul_i,
        output div_result_o, div_ready_o, div_busy_o
    );
endinterface

// File: rtl/ex_div.sv
// Iterative restoring divider for EX, one quotient bit per cycle, result {remainder, quotient}.
// Define EX_DIV_SIGNED_EN to build signed DIV support; otherwise every divide is DIVU.
module ex_div (
    input logic     clk,
    input logic     rst,
    ex_div_if.slave div_bus
);
    typedef enum logic [1:0] {S_IDLE, S_BYZERO, S_ON, S_END} state_t;

    state_t      state;
    logic [64:0] work;
    logic [4:0]  cnt;
    logic [31:0] divisor;
    logic [63:0] result;
    logic        ready;
    logic        busy;

    logic [64:0] shifted;
    logic [32:0] trial;
    logic [64:0] step;
    logic [31:0] dividend_mag;
    logic [31:0] divisor_mag;
    logic [31:0] quot_fix;
    logic [31:0] rem_fix;

    // Upper 33 bits hold the partial remainder, lower 32 collect quotient bits.
    always_comb begin
        shifted = {work[63:0], 1'b0};
        trial   = shifted[64:32] - {1'b0, divisor};
        step    = trial[32] ? shifted : {trial, shifted[31:1], 1'b1};
    end

`ifdef EX_DIV_SIGNED_EN
    logic neg_quot;
    logic neg_rem;

    always_comb begin
        dividend_mag = (div_bus.div_signed_i && div_bus.div_opdata_1_i[31])
                       ? -div_bus.div_opdata_1_i : div_bus.div_opdata_1_i;
        divisor_mag  = (div_bus.div_signed_i && div_bus.div_opdata_2_i[31])
                       ? -div_bus.div_opdata_2_i : div_bus.div_opdata_2_i;
        quot_fix     = neg_quot ? -step[31:0]  : step[31:0];
        rem_fix      = neg_rem  ? -step[63:32] : step[63:32];
    end

    // Sign decisions are taken at start so the fix-up is ready on the last step.
    always_ff @(posedge clk) begin
        if (rst) begin
            neg_quot <= 1'b0;
            neg_rem  <= 1'b0;
        end else if (state == S_IDLE && div_bus.div_start_i) begin
            neg_quot <= div_bus.div_signed_i &
                        (div_bus.div_opdata_1_i[31] ^ div_bus.div_opdata_2_i[31]);
            neg_rem  <= div_bus.div_signed_i & div_bus.div_opdata_1_i[31];
        end
    end
`else
    always_comb begin
        dividend_mag = div_bus.div_opdata_1_i;
        divisor_mag  = div_bus.div_opdata_2_i;
        quot_fix     = step[31:0];
        rem_fix      = step[63:32];
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            work    <= '0;
            cnt     <= '0;
            divisor <= '0;
            result  <= '0;
            ready   <= 1'b0;
            busy    <= 1'b0;
        end else begin
            ready <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (div_bus.div_start_i) begin
                        busy <= 1'b1;
                        if (div_bus.div_opdata_2_i != 32'd0) begin
                            state   <= S_ON;
                            work    <= {33'd0, dividend_mag};
                            divisor <= divisor_mag;
                            cnt     <= '0;
                        end else begin
                            // Divide by zero keeps the raw dividend for the remainder.
                            state <= S_BYZERO;
                            work  <= {33'd0, div_bus.div_opdata_1_i};
                        end
                    end
                end
                S_BYZERO: begin
                    if (div_bus.div_annul_i) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state  <= S_END;
                        ready  <= 1'b1;
                        result <= {work[31:0], 32'hFFFF_FFFF};
                    end
                end
                S_ON: begin
                    if (div_bus.div_annul_i) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        work <= step;
                        cnt  <= cnt + 5'd1;
                        if (cnt == 5'd31) begin
                            state  <= S_END;
                            ready  <= 1'b1;
                            result <= {rem_fix, quot_fix};
                        end
                    end
                end
                S_END: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign div_bus.div_result_o = result;
    assign div_bus.div_ready_o  = ready;
    assign div_bus.div_busy_o   = busy;
endmodule

// File: tb/tb_ex_div.sv
// Directed bench for ex_div: scoreboard of expected {remainder, quotient} values,
// latency/busy accounting, annul and mid-operation reset.
module tb_ex_div;
    logic clk = 1'b0;
    logic rst;

    ex_div_if bus ();

    ex_div dut (
        .clk     (clk),
        .rst     (rst),
        .div_bus (bus)
    );

    always #5 clk = ~clk;

    logic [63:0] sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drives one start at a negedge; the following posedge is the sampling edge E0.
    task automatic applyStimulus(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                                 input logic [63:0] exp, input bit push);
        @(negedge clk);
        bus.div_start_i    = 1'b1;
        bus.div_signed_i   = sgn;
        bus.div_opdata_1_i = a;
        bus.div_opdata_2_i = b;
        if (push) sb.push_back(exp);
        @(negedge clk);
        bus.div_start_i    = 1'b0;
    endtask

    // Called at the negedge after E0; edges counts E0 as the first edge.
    task automatic waitResult(input string tag, input int exp_edges);
        int          edges       = 1;
        int          busy_cycles = 0;
        logic [63:0] exp         = 'x;
        while (bus.div_ready_o !== 1'b1 && edges < 200) begin
            if (bus.div_busy_o === 1'b1) busy_cycles++;
            @(negedge clk);
            edges++;
        end
        if (bus.div_busy_o === 1'b1) busy_cycles++;
        if (sb.size() > 0) exp = sb.pop_front();
        checkOutput({tag, " ready"},   64'(bus.div_ready_o), 64'd1);
        checkOutput({tag, " latency"}, 64'(edges), 64'(exp_edges));
        checkOutput({tag, " busy"},    64'(busy_cycles), 64'(exp_edges));
        checkOutput({tag, " result"},  bus.div_result_o, exp);
        @(negedge clk);
        checkOutput({tag, " pulse"}, {62'd0, bus.div_ready_o, bus.div_busy_o}, 64'd0);
    endtask

    task automatic watchNoReady(input string tag, input int cycles);
        int seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (bus.div_ready_o !== 1'b0) seen++;
        end
        checkOutput({tag, " no ready"}, 64'(seen), 64'd0);
    endtask

    initial begin
        logic [63:0] last;
        logic [31:0] ra;
        logic [31:0] rb;

        bus.div_start_i    = 1'b0;
        bus.div_signed_i   = 1'b0;
        bus.div_opdata_1_i = '0;
        bus.div_opdata_2_i = '0;
        bus.div_annul_i    = 1'b0;
        rst                = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("reset result", bus.div_result_o, 64'd0);
        checkOutput("reset ready",  64'(bus.div_ready_o), 64'd0);
        checkOutput("reset busy",   64'(bus.div_busy_o), 64'd0);

        applyStimulus(1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 1'b1);
        waitResult("divu 100/7", 33);

`ifdef EX_DIV_SIGNED_EN
        applyStimulus(1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b1);
        waitResult("div -7/2", 33);
        applyStimulus(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, 1'b1);
        waitResult("div min/-1", 33);
        applyStimulus(1'b1, 32'd7, 32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD}, 1'b1);
        waitResult("div 7/-2", 33);
`else
        applyStimulus(1'b1, 32'hFFFF_FFF9, 32'd2, {32'h1, 32'h7FFF_FFFC}, 1'b1);
        waitResult("div -7/2 as divu", 33);
        applyStimulus(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h8000_0000, 32'h0}, 1'b1);
        waitResult("div min/-1 as divu", 33);
`endif

        applyStimulus(1'b0, 32'h1234, 32'd0, {32'h0000_1234, 32'hFFFF_FFFF}, 1'b1);
        waitResult("div by zero", 2);
        applyStimulus(1'b1, 32'hFFFF_FFFB, 32'd0, {32'hFFFF_FFFB, 32'hFFFF_FFFF}, 1'b1);
        waitResult("signed div by zero", 2);
        last = {32'hFFFF_FFFB, 32'hFFFF_FFFF};

        // Annul partway through the iterations.
        applyStimulus(1'b0, 32'd100, 32'd7, 64'd0, 1'b0);
        repeat (10) @(negedge clk);
        bus.div_annul_i = 1'b1;
        @(negedge clk);
        bus.div_annul_i = 1'b0;
        checkOutput("annul busy", 64'(bus.div_busy_o), 64'd0);
        watchNoReady("annul", 40);
        checkOutput("annul result held", bus.div_result_o, last);

        applyStimulus(1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 1'b1);
        waitResult("divu 9/3", 33);

        // Annul during divide-by-zero.
        applyStimulus(1'b0, 32'd5, 32'd0, 64'd0, 1'b0);
        bus.div_annul_i = 1'b1;
        @(negedge clk);
        bus.div_annul_i = 1'b0;
        checkOutput("annul byzero busy", 64'(bus.div_busy_o), 64'd0);
        watchNoReady("annul byzero", 5);
        checkOutput("annul byzero result", bus.div_result_o, {32'd0, 32'd3});

        for (int i = 0; i < 4; i++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            if (rb == 32'd0) rb = 32'd1;
            applyStimulus(1'b0, ra, rb, {ra % rb, ra / rb}, 1'b1);
            waitResult("divu random", 33);
        end

        // Reset in the middle of an operation.
        applyStimulus(1'b0, 32'd1000, 32'd3, 64'd0, 1'b0);
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midrst result", bus.div_result_o, 64'd0);
        checkOutput("midrst busy",   64'(bus.div_busy_o), 64'd0);
        checkOutput("midrst ready",  64'(bus.div_ready_o), 64'd0);
        rst = 1'b0;
        watchNoReady("midrst", 40);

        checkOutput("scoreboard drained", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
